// File: rtl/ecc_28_22_pkg.sv
// Shared widths, syndrome column constants and error encodings for the (28,22) SEC code.
package ecc_28_22_pkg;

    localparam int CW_W   = 28;
    localparam int DATA_W = 22;
    localparam int CHK_W  = 6;

    typedef logic [CHK_W-1:0] syn_t;

    // Entry i is the syndrome produced by a flip of data bit i; all have weight >= 3.
    localparam logic [DATA_W-1:0][CHK_W-1:0] SYN_COL = {
        6'h3B, 6'h37, 6'h38, 6'h34, 6'h2C, 6'h1C, 6'h32, 6'h2A, 6'h1A, 6'h26, 6'h16,
        6'h0E, 6'h31, 6'h29, 6'h19, 6'h25, 6'h15, 6'h0D, 6'h23, 6'h13, 6'h0B, 6'h07
    };

    localparam logic [1:0] ERR_NONE   = 2'b00;
    localparam logic [1:0] ERR_CORR   = 2'b01;
    localparam logic [1:0] ERR_UNCORR = 2'b10;

endpackage

// File: rtl/ecc_28_22_syn.sv
// Syndrome generator: check bits XOR the column of every set data bit.
// Latency: combinational.
// Backpressure: none, pure function of the codeword.
module ecc_28_22_syn
    import ecc_28_22_pkg::*;
(
    input  logic [CW_W-1:0]  i_cw,
    output logic [CHK_W-1:0] o_syn
);

    always_comb begin
        o_syn = i_cw[CW_W-1:DATA_W];
        for (int i = 0; i < DATA_W; i++) begin
            if (i_cw[i]) begin
                o_syn = o_syn ^ SYN_COL[i];
            end
        end
    end

endmodule

// File: rtl/ecc_28_22_dec_pipe.sv
// Two-stage (28,22) SEC decoder with optional saturating error counters (ECC_ERR_CNT_EN).
// Latency: 2 cycles, one word per cycle sustained.
// Backpressure: valid/ready skid-free pipeline; output held while stalled.
module ecc_28_22_dec_pipe
    import ecc_28_22_pkg::*;
#(
    parameter int CntW = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [CW_W-1:0]   in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [1:0]        out_err_o,
    input  logic              cnt_clr_i,
    output logic [CntW-1:0]   cnt_corr_o,
    output logic [CntW-1:0]   cnt_uncorr_o
);

    logic              r_s1_vld;
    logic [DATA_W-1:0] r_s1_dat;
    syn_t              r_s1_syn;
    logic              r_s2_vld;
    logic [DATA_W-1:0] r_s2_dat;
    logic [1:0]        r_s2_err;

    syn_t              w_syn;
    logic              w_s1_adv;
    logic              w_in_rdy;
    logic [DATA_W-1:0] w_cor_dat;
    logic [1:0]        w_cor_err;

    ecc_28_22_syn u_syn (
        .i_cw  (in_data_i),
        .o_syn (w_syn)
    );

    assign w_s1_adv = !r_s2_vld || out_ready_i;
    assign w_in_rdy = !r_s1_vld || w_s1_adv;

    // One-hot syndromes are check-bit hits: data passes through but is reported corrected.
    always_comb begin
        w_cor_dat = r_s1_dat;
        w_cor_err = ERR_NONE;
        if (r_s1_syn != '0) begin
            w_cor_err = $onehot(r_s1_syn) ? ERR_CORR : ERR_UNCORR;
            for (int i = 0; i < DATA_W; i++) begin
                if (r_s1_syn == SYN_COL[i]) begin
                    w_cor_dat[i] = ~r_s1_dat[i];
                    w_cor_err    = ERR_CORR;
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_s1_vld <= 1'b0;
            r_s1_dat <= '0;
            r_s1_syn <= '0;
            r_s2_vld <= 1'b0;
            r_s2_dat <= '0;
            r_s2_err <= ERR_NONE;
        end else begin
            if (w_in_rdy) begin
                r_s1_vld <= in_valid_i;
                if (in_valid_i) begin
                    r_s1_dat <= in_data_i[DATA_W-1:0];
                    r_s1_syn <= w_syn;
                end
            end
            if (w_s1_adv) begin
                r_s2_vld <= r_s1_vld;
                if (r_s1_vld) begin
                    r_s2_dat <= w_cor_dat;
                    r_s2_err <= w_cor_err;
                end
            end
        end
    end

    assign in_ready_o  = w_in_rdy;
    assign out_valid_o = r_s2_vld;
    assign out_data_o  = r_s2_dat;
    assign out_err_o   = r_s2_err;

`ifdef ECC_ERR_CNT_EN
    logic [CntW-1:0] r_cnt_corr;
    logic [CntW-1:0] r_cnt_uncorr;
    logic            w_out_hs;

    assign w_out_hs = r_s2_vld && out_ready_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt_corr   <= '0;
            r_cnt_uncorr <= '0;
        end else if (cnt_clr_i) begin
            r_cnt_corr   <= '0;
            r_cnt_uncorr <= '0;
        end else if (w_out_hs) begin
            if (r_s2_err == ERR_CORR && r_cnt_corr != '1) begin
                r_cnt_corr <= r_cnt_corr + CntW'(1);
            end
            if (r_s2_err == ERR_UNCORR && r_cnt_uncorr != '1) begin
                r_cnt_uncorr <= r_cnt_uncorr + CntW'(1);
            end
        end
    end

    assign cnt_corr_o   = r_cnt_corr;
    assign cnt_uncorr_o = r_cnt_uncorr;
`else
    logic w_unused_cnt_clr;

    assign w_unused_cnt_clr = cnt_clr_i;
    assign cnt_corr_o       = '0;
    assign cnt_uncorr_o     = '0;
`endif

endmodule
